// File: rtl/divider_pkg.sv
// Shared types for the iterative signed divider.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/divider_if.sv
// Operand/result handshake bundle between a producer/consumer and the divider.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the operand side and the result side.
interface divider_if #(
  parameter int DATA_LEN = 32
);
  logic                in_valid;
  logic                in_ready;
  logic [DATA_LEN-1:0] dividend;
  logic [DATA_LEN-1:0] divisor;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_LEN-1:0] quotient;
  logic [DATA_LEN-1:0] remainder;
  logic                div_by_zero;

  // Producer/consumer side
  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  // Divider side
  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/divider.sv
// Radix-2 restoring signed divider: quotient truncates toward zero, remainder takes dividend sign.
// Latency: DATA_LEN cycles from accept to out_valid, 1 cycle on divide-by-zero.
// Backpressure: result held until out_ready; no new operands accepted until the result is taken.
module divider
  import divider_pkg::*;
#(
  parameter int DATA_LEN = 32
) (
  input logic     clk,
  input logic     reset,
  divider_if.slave bus
);

  localparam int CW = $clog2(DATA_LEN);

  div_state_t          state;
  logic [CW-1:0]       cnt;
  logic [DATA_LEN-1:0] dvd_q;    // dividend magnitude, shifts out; quotient bits shift in
  logic [DATA_LEN-1:0] dsr_q;    // divisor magnitude
  logic [DATA_LEN-1:0] rem_q;    // partial remainder
  logic                sign_q;
  logic                sign_r;
  logic [DATA_LEN-1:0] quot_q;
  logic [DATA_LEN-1:0] rmdr_q;
  logic                dz_q;
  logic                out_valid_q;

  logic [DATA_LEN-1:0] dvd_abs;
  logic [DATA_LEN-1:0] dsr_abs;
  logic [DATA_LEN:0]   shifted;
  logic [DATA_LEN:0]   trial;
  logic                qbit;
  logic [DATA_LEN-1:0] rem_nxt;
  logic [DATA_LEN-1:0] dvd_nxt;

  // Operand magnitudes; the most-negative value maps onto itself, which is the correct unsigned magnitude.
  always_comb begin
    dvd_abs = bus.dividend[DATA_LEN-1] ? -bus.dividend : bus.dividend;
    dsr_abs = bus.divisor[DATA_LEN-1]  ? -bus.divisor  : bus.divisor;
  end

  // One restoring step: shift, trial-subtract with an extra bit so the borrow is the sign.
  always_comb begin
    shifted = {rem_q, dvd_q[DATA_LEN-1]};
    trial   = shifted - {1'b0, dsr_q};
    qbit    = ~trial[DATA_LEN];
    rem_nxt = qbit ? trial[DATA_LEN-1:0] : shifted[DATA_LEN-1:0];
    dvd_nxt = {dvd_q[DATA_LEN-2:0], qbit};
  end

  // Control FSM, iteration datapath and registered result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      rem_q       <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      quot_q      <= '0;
      rmdr_q      <= '0;
      dz_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            dvd_q  <= dvd_abs;
            dsr_q  <= dsr_abs;
            sign_q <= bus.dividend[DATA_LEN-1] ^ bus.divisor[DATA_LEN-1];
            sign_r <= bus.dividend[DATA_LEN-1];
            rem_q  <= '0;
            cnt    <= CW'(DATA_LEN - 1);
            state  <= (bus.divisor == '0) ? DONE : BUSY;
          end
        end
        BUSY: begin
          rem_q <= rem_nxt;
          dvd_q <= dvd_nxt;
          if (cnt == '0) begin
            state       <= DONE;
            quot_q      <= sign_q ? -dvd_nxt : dvd_nxt;
            rmdr_q      <= sign_r ? -rem_nxt : rem_nxt;
            dz_q        <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          // Entering DONE without a loaded result only happens on divide-by-zero.
          if (!out_valid_q) begin
            quot_q      <= '1;
            rmdr_q      <= sign_r ? -dvd_q : dvd_q;
            dz_q        <= 1'b1;
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (state == IDLE) && !reset;
  assign bus.out_valid   = out_valid_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rmdr_q;
  assign bus.div_by_zero = dz_q;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for the iterative signed divider.
// Latency: checks DATA_LEN-cycle and divide-by-zero result timing.
// Backpressure: exercises held results, ignored inputs and reset abort.
module tb_divider;

  localparam int N = 32;

  logic clk = 1'b0;
  logic reset;
  int   cyc_cnt = 0;
  int   checks  = 0;
  int   passed  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  divider_if #(.DATA_LEN(N)) bus ();

  divider #(.DATA_LEN(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
  } exp_t;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
  } vec_t;

  exp_t sb[$];

  // Reference model in 64-bit arithmetic, so the overflow case cannot trap.
  function automatic exp_t model(logic [N-1:0] a, logic [N-1:0] b);
    exp_t   e;
    longint sa, sd, qq, rr;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dz = 1'b1;
    end else begin
      sa = longint'($signed(a));
      sd = longint'($signed(b));
      qq = sa / sd;
      rr = sa % sd;
      e.q = N'(qq); e.r = N'(rr); e.dz = 1'b0;
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands until accepted; returns at accept edge + 1.
  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, output bit ok, output int t_acc);
    bus.dividend = a;
    bus.divisor  = b;
    bus.in_valid = 1'b1;
    ok    = 1'b0;
    t_acc = -1;
    for (int i = 0; i < 200; i++) begin
      if (bus.in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (ok) begin
      step();
      t_acc = cyc_cnt;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
      cyc++;
    end
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.quotient !== '0 ||
        bus.remainder !== '0 || bus.div_by_zero !== 1'b0)
      $display("FAIL reset_state got rdy=%b vld=%b q=%h r=%h dz=%b want 0/0/0/0/0",
               bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero);
    else passed++;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL reset_release in_ready got %b want 1", bus.in_ready);
    else passed++;
  endtask

  task automatic test_signs();
    vec_t v[8];
    bit   acc, got;
    int   cyc, t;
    exp_t e;
    v[0] = '{32'd100,         32'd7,          32'd14,         32'd2};
    v[1] = '{-32'sd100,       32'd7,          -32'sd14,       -32'sd2};
    v[2] = '{32'd100,         -32'sd7,        -32'sd14,       32'd2};
    v[3] = '{-32'sd100,       -32'sd7,        32'd14,         -32'sd2};
    v[4] = '{32'd5,           32'd100,        32'd0,          32'd5};
    v[5] = '{32'd0,           -32'sd3,        32'd0,          32'd0};
    v[6] = '{32'h8000_0000,   32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
    v[7] = '{32'h8000_0000,   32'd1,          32'h8000_0000,  32'd0};
    sb.delete();
    for (int i = 0; i < 8; i++) begin
      send(v[i].a, v[i].b, acc, t);
      if (acc) sb.push_back('{v[i].q, v[i].r, 1'b0});
      wait_out(cyc, got);
      checks++;
      if (!acc || !got || cyc != N) $display("FAIL signs_latency[%0d] got %0d cycles want %0d", i, cyc, N);
      else passed++;
      if (got && sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {e.q, e.r, e.dz})
          $display("FAIL signs_result[%0d] got q=%h r=%h dz=%b want q=%h r=%h dz=%b",
                   i, bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.dz);
        else passed++;
        handshake();
      end
    end
  endtask

  task automatic test_div_zero();
    logic [N-1:0] a[2];
    bit   acc, got;
    int   cyc, t;
    exp_t e;
    a[0] = 32'd7;
    a[1] = -32'sd5;
    sb.delete();
    for (int i = 0; i < 2; i++) begin
      send(a[i], '0, acc, t);
      if (acc) sb.push_back('{32'hFFFF_FFFF, a[i], 1'b1});
      wait_out(cyc, got);
      checks++;
      if (!acc || !got || cyc != 1) $display("FAIL dz_latency[%0d] got %0d cycles want 1", i, cyc);
      else passed++;
      if (got && sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {e.q, e.r, e.dz})
          $display("FAIL dz_result[%0d] got q=%h r=%h dz=%b want q=%h r=%h dz=%b",
                   i, bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.dz);
        else passed++;
        handshake();
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] a, b;
    bit   acc, got;
    int   cyc, t;
    exp_t e;
    sb.delete();
    for (int i = 0; i < 12; i++) begin
      a = $urandom();
      b = ($urandom_range(0, 2) == 0) ? N'($signed($urandom_range(0, 40)) - 20) : N'($urandom());
      send(a, b, acc, t);
      if (acc) sb.push_back(model(a, b));
      wait_out(cyc, got);
      if (got && sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (cyc != ((b == '0) ? 1 : N) ||
            {bus.quotient, bus.remainder, bus.div_by_zero} !== {e.q, e.r, e.dz})
          $display("FAIL random[%0d] %h/%h got q=%h r=%h dz=%b cyc=%0d want q=%h r=%h dz=%b",
                   i, a, b, bus.quotient, bus.remainder, bus.div_by_zero, cyc, e.q, e.r, e.dz);
        else passed++;
        handshake();
      end else begin
        checks++;
        $display("FAIL random[%0d] no result accepted=%b", i, acc);
      end
    end
  endtask

  task automatic test_backpressure();
    bit   acc, got, bad;
    int   cyc, t;
    exp_t e;
    sb.delete();
    send(32'd1000, 32'd10, acc, t);
    if (acc) sb.push_back('{32'd100, 32'd0, 1'b0});
    wait_out(cyc, got);
    bus.dividend = 32'd77;
    bus.divisor  = -32'sd5;
    bus.in_valid = 1'b1;
    bad = !got || sb.size() == 0;
    e   = (sb.size() > 0) ? sb.pop_front() : '{'0, '0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bad || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          {bus.quotient, bus.remainder, bus.div_by_zero} !== {e.q, e.r, e.dz})
        $display("FAIL bp_hold[%0d] got vld=%b rdy=%b q=%h r=%h want 1/0/%h/%h",
                 i, bus.out_valid, bus.in_ready, bus.quotient, bus.remainder, e.q, e.r);
      else passed++;
      step();
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL bp_release got vld=%b rdy=%b want 0/1", bus.out_valid, bus.in_ready);
    else passed++;
    step();
    bus.in_valid = 1'b0;
    sb.push_back('{-32'sd15, 32'd2, 1'b0});
    checks++;
    if (bus.in_ready !== 1'b0) $display("FAIL bp_second_accept in_ready got %b want 0", bus.in_ready);
    else passed++;
    wait_out(cyc, got);
    e = sb.pop_front();
    checks++;
    if (!got || cyc != N || {bus.quotient, bus.remainder, bus.div_by_zero} !== {e.q, e.r, e.dz})
      $display("FAIL bp_second_result got q=%h r=%h cyc=%0d want q=%h r=%h cyc=%0d",
               bus.quotient, bus.remainder, cyc, e.q, e.r, N);
    else passed++;
    handshake();
  endtask

  task automatic test_back_to_back();
    bit   acc_a, acc_b, got_a, got_b;
    int   t_a, t_b, cyc_a, cyc_b;
    exp_t e;
    sb.delete();
    bus.out_ready = 1'b1;
    send(-32'sd7, 32'd2, acc_a, t_a);
    if (acc_a) sb.push_back('{-32'sd3, -32'sd1, 1'b0});
    fork
      send(32'd12345, -32'sd100, acc_b, t_b);
      begin
        wait_out(cyc_a, got_a);
        checks++;
        if (!got_a || sb.size() == 0) $display("FAIL b2b_first no result");
        else begin
          e = sb.pop_front();
          if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {e.q, e.r, e.dz})
            $display("FAIL b2b_first got q=%h r=%h want q=%h r=%h", bus.quotient, bus.remainder, e.q, e.r);
          else passed++;
        end
      end
    join
    if (acc_b) sb.push_back('{-32'sd123, 32'd45, 1'b0});
    checks++;
    if (!acc_a || !acc_b || (t_b - t_a) != N + 2)
      $display("FAIL b2b_spacing got %0d cycles want %0d", t_b - t_a, N + 2);
    else passed++;
    wait_out(cyc_b, got_b);
    checks++;
    if (!got_b || sb.size() == 0) $display("FAIL b2b_second no result");
    else begin
      e = sb.pop_front();
      if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {e.q, e.r, e.dz})
        $display("FAIL b2b_second got q=%h r=%h want q=%h r=%h", bus.quotient, bus.remainder, e.q, e.r);
      else passed++;
    end
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_abort();
    bit   acc, got, seen;
    int   cyc, t;
    exp_t e;
    sb.delete();
    send(32'd1000, 32'd3, acc, t);
    repeat (10) step();
    reset = 1'b1;
    step();
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0)
      $display("FAIL abort_in_reset got rdy=%b vld=%b want 0/0", bus.in_ready, bus.out_valid);
    else passed++;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL abort_release in_ready got %b want 1", bus.in_ready);
    else passed++;
    seen = 1'b0;
    for (int i = 0; i < N + 8; i++) begin
      if (bus.out_valid !== 1'b0) seen = 1'b1;
      step();
    end
    checks++;
    if (seen) $display("FAIL abort_stale out_valid got 1 want 0");
    else passed++;
    send(32'd9, 32'd3, acc, t);
    if (acc) sb.push_back('{32'd3, 32'd0, 1'b0});
    wait_out(cyc, got);
    checks++;
    if (!got || sb.size() == 0 || cyc != N) $display("FAIL abort_fresh no result cyc=%0d want %0d", cyc, N);
    else begin
      e = sb.pop_front();
      if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {e.q, e.r, e.dz})
        $display("FAIL abort_fresh got q=%h r=%h want q=%h r=%h", bus.quotient, bus.remainder, e.q, e.r);
      else passed++;
    end
    handshake();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_signs();
    test_div_zero();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
